// File: rtl/ppm_decoder_n.sv
// 1-of-2^BPS pulse-position-modulation frame decoder with OSR clocks per slot.
// Emits assembled bytes with a strobe, SOF/EOF/abort pulses and a per-frame byte count.
module ppm_decoder_n #(
    parameter int BPS       = 2,
    parameter int OSR       = 16,
    parameter int MAX_BYTES = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Din,
    output logic [7:0]       Dout,
    output logic             D_en,
    output logic             F_en,
    output logic             sof_det,
    output logic             eof_det,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] byte_cnt
);
    localparam int NSLOT = 1 << BPS;
    localparam int SYMS  = 8 / BPS;
    localparam int PH_W  = $clog2(OSR);
    localparam int SYM_W = (SYMS > 1) ? $clog2(SYMS) : 1;

    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OSR / 2);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
    localparam logic [BPS-1:0]   SLOT_ONE  = BPS'(1);
    localparam logic [BPS-1:0]   SLOT_LAST = BPS'(NSLOT - 1);
    localparam logic [NSLOT-1:0] MASK_ONE  = NSLOT'(1);
    localparam logic [NSLOT-1:0] SOF_MASK  = NSLOT'(3);
    localparam logic [SYM_W-1:0] SYM_ONE   = SYM_W'(1);
    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {HUNT, SOF, DATA} state_t;

    function automatic logic [BPS-1:0] slot_index(input logic [NSLOT-1:0] m);
        logic [BPS-1:0] r;
        r = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (m[i]) r = BPS'(i);
        end
        return r;
    endfunction

    state_t           state;
    logic             din_p0, ds, ds_q;
    logic [PH_W-1:0]  phase;
    logic [BPS-1:0]   slot;
    logic [NSLOT-1:0] mask;
    logic [7-BPS:0]   acc_q;
    logic [SYM_W-1:0] sym_cnt;

    logic             rise, sym_end, one_hot;
    logic [BPS-1:0]   hot_idx;
    logic [7:0]       byte_nxt;

    always_comb begin
        rise     = ds & ~ds_q;
        sym_end  = (state != HUNT) && (phase == PH_LAST) && (slot == SLOT_LAST);
        one_hot  = (mask != '0) && ((mask & (mask - MASK_ONE)) == '0);
        hot_idx  = slot_index(mask);
        byte_nxt = {acc_q, hot_idx};
    end

    // Stage p0/p1: line synchroniser, then slot sampling and byte assembly
    always_ff @(posedge clk) begin
        din_p0 <= Din;
        ds     <= din_p0;
        ds_q   <= ds;
        if (state == HUNT || sym_end) begin
            mask <= '0;
        end else if (phase == PH_MID) begin
            mask[slot] <= ds;
        end
        if (sym_end && state == SOF) begin
            acc_q <= '0;
        end else if (sym_end && state == DATA && one_hot) begin
            acc_q <= byte_nxt[7-BPS:0];
        end
    end

    // Stage p2: frame control and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            phase    <= '0;
            slot     <= '0;
            sym_cnt  <= '0;
            Dout     <= '0;
            D_en     <= 1'b0;
            F_en     <= 1'b0;
            sof_det  <= 1'b0;
            eof_det  <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            byte_cnt <= '0;
        end else begin
            D_en    <= 1'b0;
            sof_det <= 1'b0;
            eof_det <= 1'b0;
            err     <= 1'b0;
            if (state == HUNT) begin
                // The rise cycle itself is phase 0 of slot 0
                if (rise) begin
                    phase <= PH_ONE;
                    slot  <= '0;
                    state <= SOF;
                end
            end else begin
                if (phase == PH_LAST) begin
                    phase <= '0;
                    slot  <= slot + SLOT_ONE;
                end else begin
                    phase <= phase + PH_ONE;
                end
                if (sym_end) begin
                    if (state == SOF) begin
                        if (mask == SOF_MASK) begin
                            sof_det  <= 1'b1;
                            F_en     <= 1'b1;
                            byte_cnt <= '0;
                            sym_cnt  <= '0;
                            state    <= DATA;
                        end else begin
                            state <= HUNT;
                        end
                    end else if (mask == '0) begin
                        F_en  <= 1'b0;
                        state <= HUNT;
                        if (sym_cnt != '0) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else begin
                            eof_det <= 1'b1;
                        end
                    end else if (!one_hot) begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                        F_en     <= 1'b0;
                        state    <= HUNT;
                    end else if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        if (byte_cnt == CNT_MAX) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                            F_en     <= 1'b0;
                            state    <= HUNT;
                        end else begin
                            Dout     <= byte_nxt;
                            D_en     <= 1'b1;
                            byte_cnt <= byte_cnt + CNT_ONE;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + SYM_ONE;
                    end
                end
            end
        end
    end

endmodule
